vga_plot_arbiter: RTL and testbench
===================================

// Module: vga_plot_arbiter
// PURPOSE
//   Round-robin arbiter sharing the single vga_adapter plot port (x, y, colour, plot) among
//   N_REQ shape-drawing units (arrow/shape datapaths with their control FSMs).
//   A unit requests, is granted exclusive ownership for one drawing burst, then releases.
//   Forwarded pixel signals are registered, with a burst cap so no unit can starve the others.
// PARAMETERS
//   N_REQ      4    number of requesting drawing units (2..8)
//   MAX_BURST  255  max accepted pixels per grant before forced release (1..255)
//   CW         3    colour width in bits
// PORTS
//   clk            in   1             system clock (CLOCK_50 domain)
//   reset          in   1             asynchronous, active-high reset
//   req            in   N_REQ         per-unit request, held high for the whole burst
//   last           in   N_REQ         per-unit end-of-burst marker, qualified by plot_in
//   plot_in        in   N_REQ         per-unit pixel-valid strobe
//   x_in           in   8*N_REQ       per-unit x; unit i uses bits [8i+7:8i]
//   y_in           in   7*N_REQ       per-unit y; unit i uses bits [7i+6:7i]
//   colour_in      in   CW*N_REQ      per-unit colour; unit i uses bits [CW*i+CW-1:CW*i]
//   grant          out  N_REQ         one-hot ownership, registered
//   x              out  8             to vga_adapter .x
//   y              out  7             to vga_adapter .y
//   colour         out  CW            to vga_adapter .colour
//   plot           out  1             to vga_adapter .plot
//   owner          out  clog2(N_REQ)  index of current or most recent owner
//   busy           out  1             high while in OWN state
//   forced_release out  1             1-cycle pulse when MAX_BURST ends a grant
// BEHAVIOUR
// - Reset:
//   - Asserting reset immediately clears the following outputs to 0: grant, x, y, colour,
//     plot, owner, busy, forced_release, and the burst counter.
//   - State goes to IDLE; the round-robin pointer last_owner goes to N_REQ-1, so unit 0 has
//     first priority.
//   - A reset during a burst aborts it. The in-flight pixel is dropped; this is acceptable.
// - FSM states: IDLE, OWN, RELEASE.
//   - IDLE, when any req is high:
//     - Pick the first set req scanning from last_owner+1 mod N_REQ upward, with wrap.
//     - Next cycle: grant[sel]=1, owner=sel, busy=1, counter=0, state OWN.
//     - Request-to-grant latency is exactly 1 cycle.
//   - OWN, each cycle:
//     - Accept a pixel when plot_in[owner] is high. Accepted pixels do not depend on req.
//     - On an accepted pixel, on the next edge: x/y/colour get owner's slice, plot=1,
//       counter+1. Pixel latency is exactly 1 cycle.
//     - With no accepted pixel: plot=0 and x/y/colour hold their last values.
//     - plot_in, last and x/y/colour from non-owners are ignored.
//   - OWN exit: leave to RELEASE on the edge where any of these holds:
//     - (a) req[owner]==0;
//     - (b) plot_in[owner] & last[owner];
//     - (c) the accepted pixel makes counter==MAX_BURST.
//     - The pixel on the exit cycle is still forwarded.
//     - forced_release pulses for 1 cycle, together with entry to RELEASE, only when (c)
//       is the cause and (a)/(b) do not also hold. (a)/(b) take priority for the pulse.
//   - RELEASE, one cycle:
//     - grant=0, busy=0, last_owner=owner.
//     - plot=0 after the final forwarded pixel drains.
//     - Then IDLE.
//     - This guarantees a >=1-cycle grant gap, so a re-requesting unit loses to any other
//       pending unit.
// - The counter is 8 bits. It never wraps in OWN, because the cap forces exit at
//   MAX_BURST.
// - owner holds its value through RELEASE and IDLE.
// - The grant is one-hot or zero at all times.
// - A new req arriving during OWN or RELEASE waits. Arbitration happens only in IDLE.
// TESTING
// 1. Reset, then req=4'b0001 at cycle 0 -> grant=0001 at cycle 1, busy=1; plot_in[0] with
//    x=79,y=63 at cycle 2 -> plot=1,x=79,y=63 at cycle 3.
// 2. req=4'b1111 held, each unit bursts 3 pixels with last on the 3rd -> grant order
//    0,1,2,3,0; RELEASE gap of 1 cycle between grants; no overlap.
// 3. MAX_BURST=4, unit 2 plots continuously without last -> 4 plot pulses, then
//    forced_release=1 for 1 cycle, grant drops; the 5th pixel is not forwarded.
// 4. Owner 1 drops req on the same cycle as plot_in -> that pixel appears on plot next
//    cycle, then RELEASE; unit 3 (pending) is granted before unit 1 re-requests.
// 5. Non-owner plot_in[3]=1 with x=10 while unit 0 owns -> plot and x unaffected.
// 6. Assert reset mid-burst -> all outputs 0 in the same cycle; after release, req=4'b0110
//    -> unit 1 granted first.

Source files
------------

// File: rtl/vga_plot_arbiter.sv
// Round-robin arbiter that shares one vga_adapter plot port among N_REQ
// drawing units. A unit gets exclusive ownership for one burst. Its pixels
// are forwarded through a register stage. A burst cap stops any one unit
// from starving the others.
module vga_plot_arbiter #(
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = 255,
  parameter int CW        = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          last,
  input  logic [N_REQ-1:0]          plot_in,
  input  logic [8*N_REQ-1:0]        x_in,
  input  logic [7*N_REQ-1:0]        y_in,
  input  logic [CW*N_REQ-1:0]       colour_in,
  output logic [N_REQ-1:0]          grant,
  output logic [7:0]                x,
  output logic [6:0]                y,
  output logic [CW-1:0]             colour,
  output logic                      plot,
  output logic [$clog2(N_REQ)-1:0]  owner,
  output logic                      busy,
  output logic                      forced_release
);

  localparam int OW = $clog2(N_REQ);

  typedef enum logic [1:0] {S_IDLE, S_OWN, S_RELEASE} state_t;

  state_t           r_state, w_state_nxt;
  logic [N_REQ-1:0] r_grant, w_grant_nxt;
  logic [7:0]       r_x, w_x_nxt;
  logic [6:0]       r_y, w_y_nxt;
  logic [CW-1:0]    r_colour, w_colour_nxt;
  logic             r_plot, w_plot_nxt;
  logic [OW-1:0]    r_owner, w_owner_nxt;
  logic [OW-1:0]    r_last_owner, w_last_owner_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_fr, w_fr_nxt;
  logic [7:0]       r_cnt, w_cnt_nxt;

  logic [N_REQ-1:0] w_rot;
  logic [OW-1:0]    w_sel;
  logic             w_any;

  logic             w_o_req, w_o_last, w_o_plot;
  logic [7:0]       w_o_x;
  logic [6:0]       w_o_y;
  logic [CW-1:0]    w_o_colour;

  logic [7:0]       w_cnt_inc;
  logic             w_exit_req, w_exit_last, w_exit_cap;

  // Rotate requests so bit 0 is the unit right after the last owner, then take the lowest set bit
  always_comb begin
    int v_off;
    v_off = 0;
    w_any = |req;
    w_rot = N_REQ'({req, req} >> ({1'b0, r_last_owner} + 1'b1));
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (w_rot[j]) v_off = j;
    end
    w_sel = OW'((int'(r_last_owner) + 1 + v_off) % N_REQ);
  end

  // Pick out the current owner's request, strobe and pixel fields
  always_comb begin
    w_o_req    = 1'b0;
    w_o_last   = 1'b0;
    w_o_plot   = 1'b0;
    w_o_x      = '0;
    w_o_y      = '0;
    w_o_colour = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_owner == OW'(i)) begin
        w_o_req    = req[i];
        w_o_last   = last[i];
        w_o_plot   = plot_in[i];
        w_o_x      = x_in[8*i +: 8];
        w_o_y      = y_in[7*i +: 7];
        w_o_colour = colour_in[CW*i +: CW];
      end
    end
  end

  assign w_cnt_inc   = r_cnt + 8'd1;
  assign w_exit_req  = ~w_o_req;
  assign w_exit_last = w_o_plot & w_o_last;
  assign w_exit_cap  = w_o_plot & (w_cnt_inc == 8'(MAX_BURST));

  // Next-state and next-output logic; plot and forced_release default to a 1-cycle pulse
  always_comb begin
    w_state_nxt      = r_state;
    w_grant_nxt      = r_grant;
    w_x_nxt          = r_x;
    w_y_nxt          = r_y;
    w_colour_nxt     = r_colour;
    w_plot_nxt       = 1'b0;
    w_owner_nxt      = r_owner;
    w_last_owner_nxt = r_last_owner;
    w_busy_nxt       = r_busy;
    w_fr_nxt         = 1'b0;
    w_cnt_nxt        = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_nxt = S_OWN;
          w_grant_nxt = {{(N_REQ-1){1'b0}}, 1'b1} << w_sel;
          w_owner_nxt = w_sel;
          w_busy_nxt  = 1'b1;
          w_cnt_nxt   = '0;
        end
      end
      S_OWN: begin
        if (w_o_plot) begin
          w_x_nxt      = w_o_x;
          w_y_nxt      = w_o_y;
          w_colour_nxt = w_o_colour;
          w_plot_nxt   = 1'b1;
          w_cnt_nxt    = w_cnt_inc;
        end
        if (w_exit_req || w_exit_last || w_exit_cap) begin
          w_state_nxt      = S_RELEASE;
          w_grant_nxt      = '0;
          w_busy_nxt       = 1'b0;
          w_last_owner_nxt = r_owner;
          w_fr_nxt         = w_exit_cap & ~w_exit_req & ~w_exit_last;
        end
      end
      S_RELEASE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any burst in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_grant      <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_colour     <= '0;
      r_plot       <= 1'b0;
      r_owner      <= '0;
      r_last_owner <= OW'(N_REQ - 1);
      r_busy       <= 1'b0;
      r_fr         <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_x          <= w_x_nxt;
      r_y          <= w_y_nxt;
      r_colour     <= w_colour_nxt;
      r_plot       <= w_plot_nxt;
      r_owner      <= w_owner_nxt;
      r_last_owner <= w_last_owner_nxt;
      r_busy       <= w_busy_nxt;
      r_fr         <= w_fr_nxt;
      r_cnt        <= w_cnt_nxt;
    end
  end

  assign grant          = r_grant;
  assign x              = r_x;
  assign y              = r_y;
  assign colour         = r_colour;
  assign plot           = r_plot;
  assign owner          = r_owner;
  assign busy           = r_busy;
  assign forced_release = r_fr;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Directed bench for vga_plot_arbiter (N_REQ=4, MAX_BURST=4, CW=3).
module tb_vga_plot_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req, last, plot_in;
  logic [31:0] x_in;
  logic [27:0] y_in;
  logic [11:0] colour_in;
  logic [3:0]  grant;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot;
  logic [1:0]  owner;
  logic        busy;
  logic        forced_release;

  int n_checks = 0;
  int n_errors = 0;

  vga_plot_arbiter #(.N_REQ(4), .MAX_BURST(4), .CW(3)) dut (
    .clk(clk), .reset(reset), .req(req), .last(last), .plot_in(plot_in),
    .x_in(x_in), .y_in(y_in), .colour_in(colour_in), .grant(grant),
    .x(x), .y(y), .colour(colour), .plot(plot), .owner(owner),
    .busy(busy), .forced_release(forced_release)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req, last, pin;
    logic [31:0] xin;
    logic [27:0] yin;
    logic [11:0] cin;
    logic [3:0]  e_grant;
    logic        e_plot;
    logic [7:0]  e_x;
    logic [6:0]  e_y;
    logic [2:0]  e_col;
    logic [1:0]  e_owner;
    logic        e_busy, e_fr;
  } vec_t;

  vec_t vecs[23];

  function automatic logic [31:0] px(input int u, input logic [7:0] v);
    return {24'd0, v} << (8*u);
  endfunction
  function automatic logic [27:0] py(input int u, input logic [6:0] v);
    return {21'd0, v} << (7*u);
  endfunction
  function automatic logic [11:0] pc(input int u, input logic [2:0] v);
    return {9'd0, v} << (3*u);
  endfunction

  function automatic vec_t mk(input logic [3:0] r, input logic [3:0] l, input logic [3:0] p,
                              input logic [31:0] xi, input logic [27:0] yi, input logic [11:0] ci,
                              input logic [3:0] g, input logic pl, input logic [7:0] ex,
                              input logic [6:0] ey, input logic [2:0] ec, input logic [1:0] eo,
                              input logic eb, input logic ef);
    vec_t v;
    v.req = r; v.last = l; v.pin = p; v.xin = xi; v.yin = yi; v.cin = ci;
    v.e_grant = g; v.e_plot = pl; v.e_x = ex; v.e_y = ey; v.e_col = ec;
    v.e_owner = eo; v.e_busy = eb; v.e_fr = ef;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"}, 32'(grant), 0);
    chk({tag, "_x"}, 32'(x), 0);
    chk({tag, "_y"}, 32'(y), 0);
    chk({tag, "_colour"}, 32'(colour), 0);
    chk({tag, "_plot"}, 32'(plot), 0);
    chk({tag, "_owner"}, 32'(owner), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_fr"}, 32'(forced_release), 0);
  endtask

  initial begin
    bit got;
    int exp_u;

    // Table: reset -> unit0 burst, non-owner ignored, req-drop exit, fairness, cap, cap+last
    vecs[0]  = mk(4'b0001, 4'b0000, 4'b0000, 0, 0, 0,                                 4'b0001, 0, 0, 0, 0, 0, 1, 0);
    vecs[1]  = mk(4'b0001, 4'b0000, 4'b0001, px(0,79), py(0,63), pc(0,5),             4'b0001, 1, 79, 63, 5, 0, 1, 0);
    vecs[2]  = mk(4'b0001, 4'b0000, 4'b1000, px(3,10)|px(0,1), py(3,9), pc(3,7),      4'b0001, 0, 79, 63, 5, 0, 1, 0);
    vecs[3]  = mk(4'b0001, 4'b0001, 4'b0001, px(0,20), py(0,21), pc(0,2),             4'b0000, 1, 20, 21, 2, 0, 0, 0);
    vecs[4]  = mk(4'b0000, 4'b0000, 4'b0000, 0, 0, 0,                                 4'b0000, 0, 20, 21, 2, 0, 0, 0);
    vecs[5]  = mk(4'b0010, 4'b0000, 4'b0000, 0, 0, 0,                                 4'b0010, 0, 20, 21, 2, 1, 1, 0);
    vecs[6]  = mk(4'b1000, 4'b0000, 4'b0010, px(1,33), py(1,44), pc(1,6),             4'b0000, 1, 33, 44, 6, 1, 0, 0);
    vecs[7]  = mk(4'b1010, 4'b0000, 4'b0000, 0, 0, 0,                                 4'b0000, 0, 33, 44, 6, 1, 0, 0);
    vecs[8]  = mk(4'b1010, 4'b0000, 4'b0000, 0, 0, 0,                                 4'b1000, 0, 33, 44, 6, 3, 1, 0);
    vecs[9]  = mk(4'b0000, 4'b0000, 4'b0000, 0, 0, 0,                                 4'b0000, 0, 33, 44, 6, 3, 0, 0);
    vecs[10] = mk(4'b0000, 4'b0000, 4'b0000, 0, 0, 0,                                 4'b0000, 0, 33, 44, 6, 3, 0, 0);
    vecs[11] = mk(4'b0100, 4'b0000, 4'b0000, 0, 0, 0,                                 4'b0100, 0, 33, 44, 6, 2, 1, 0);
    vecs[12] = mk(4'b0100, 4'b0000, 4'b0100, px(2,101), py(2,1), pc(2,1),             4'b0100, 1, 101, 1, 1, 2, 1, 0);
    vecs[13] = mk(4'b0100, 4'b0000, 4'b0100, px(2,102), py(2,2), pc(2,2),             4'b0100, 1, 102, 2, 2, 2, 1, 0);
    vecs[14] = mk(4'b0100, 4'b0000, 4'b0100, px(2,103), py(2,3), pc(2,3),             4'b0100, 1, 103, 3, 3, 2, 1, 0);
    vecs[15] = mk(4'b0100, 4'b0000, 4'b0100, px(2,104), py(2,4), pc(2,4),             4'b0000, 1, 104, 4, 4, 2, 0, 1);
    vecs[16] = mk(4'b0100, 4'b0000, 4'b0100, px(2,105), py(2,5), pc(2,5),             4'b0000, 0, 104, 4, 4, 2, 0, 0);
    vecs[17] = mk(4'b0100, 4'b0000, 4'b0100, px(2,105), py(2,5), pc(2,5),             4'b0100, 0, 104, 4, 4, 2, 1, 0);
    vecs[18] = mk(4'b0100, 4'b0000, 4'b0100, px(2,106), py(2,6), pc(2,6),             4'b0100, 1, 106, 6, 6, 2, 1, 0);
    vecs[19] = mk(4'b0100, 4'b0000, 4'b0100, px(2,107), py(2,7), pc(2,7),             4'b0100, 1, 107, 7, 7, 2, 1, 0);
    vecs[20] = mk(4'b0100, 4'b0000, 4'b0100, px(2,108), py(2,8), pc(2,0),             4'b0100, 1, 108, 8, 0, 2, 1, 0);
    vecs[21] = mk(4'b0100, 4'b0100, 4'b0100, px(2,109), py(2,9), pc(2,1),             4'b0000, 1, 109, 9, 1, 2, 0, 0);
    vecs[22] = mk(4'b0000, 4'b0000, 4'b0000, 0, 0, 0,                                 4'b0000, 0, 109, 9, 1, 2, 0, 0);

    reset = 1'b1; req = '0; last = '0; plot_in = '0; x_in = '0; y_in = '0; colour_in = '0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      req = vecs[i].req; last = vecs[i].last; plot_in = vecs[i].pin;
      x_in = vecs[i].xin; y_in = vecs[i].yin; colour_in = vecs[i].cin;
      @(posedge clk); #1;
      chk($sformatf("v%0d_grant", i), 32'(grant), 32'(vecs[i].e_grant));
      chk($sformatf("v%0d_plot", i), 32'(plot), 32'(vecs[i].e_plot));
      chk($sformatf("v%0d_x", i), 32'(x), 32'(vecs[i].e_x));
      chk($sformatf("v%0d_y", i), 32'(y), 32'(vecs[i].e_y));
      chk($sformatf("v%0d_colour", i), 32'(colour), 32'(vecs[i].e_col));
      chk($sformatf("v%0d_owner", i), 32'(owner), 32'(vecs[i].e_owner));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
      chk($sformatf("v%0d_fr", i), 32'(forced_release), 32'(vecs[i].e_fr));
    end

    // Reset mid-burst: outputs clear asynchronously, then unit 1 wins from req=0110
    @(negedge clk);
    req = 4'b0001; last = '0; plot_in = '0;
    @(negedge clk);
    plot_in = 4'b0001; x_in = px(0,55); y_in = py(0,11); colour_in = pc(0,3);
    @(posedge clk); #1;
    chk("mid_plot_before_reset", 32'(plot), 1);
    @(negedge clk); #2;
    reset = 1'b1; #1;
    chk_all_zero("async_reset");
    @(negedge clk);
    reset = 1'b0; req = 4'b0110; plot_in = '0; x_in = '0; y_in = '0; colour_in = '0;
    @(posedge clk); #1;
    chk("post_reset_grant", 32'(grant), 32'b0010);
    chk("post_reset_owner", 32'(owner), 1);
    chk("post_reset_busy", 32'(busy), 1);
    @(negedge clk);
    req = '0;
    repeat (3) @(negedge clk);

    // Round robin with all units requesting, 3-pixel bursts ending with last
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; req = 4'b1111;
    for (int b = 0; b < 5; b++) begin
      exp_u = b % 4;
      got = 1'b0;
      for (int c = 0; c < 8 && !got; c++) begin
        @(posedge clk); #1;
        chk($sformatf("rr%0d_onehot", b), 32'($onehot0(grant)), 1);
        if (grant != 4'b0000) got = 1'b1;
      end
      if (!got) chk($sformatf("rr%0d_timeout", b), 0, 1);
      chk($sformatf("rr%0d_grant", b), 32'(grant), 32'(4'b0001 << exp_u));
      for (int p = 0; p < 3; p++) begin
        @(negedge clk);
        plot_in = 4'b0001 << exp_u;
        last = (p == 2) ? (4'b0001 << exp_u) : 4'b0000;
        x_in = px(exp_u, 8'(200 + 10*b + p));
        @(posedge clk); #1;
        chk($sformatf("rr%0d_p%0d_plot", b, p), 32'(plot), 1);
        chk($sformatf("rr%0d_p%0d_x", b, p), 32'(x), 32'(200 + 10*b + p));
        chk($sformatf("rr%0d_p%0d_grant", b, p), 32'(grant), (p == 2) ? 0 : 32'(4'b0001 << exp_u));
      end
      @(negedge clk);
      plot_in = '0; last = '0;
    end
    req = '0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
